kmp_match_engine: RTL
=====================

# kmp_match_engine

Downstream consumer of the shared-memory/failure-function stage in the string-matching engine. Takes the loaded string buffer, pattern buffer, last-index values and per-position failure-function table, plus the upstream `valid` pulse. Runs a Knuth-Morris-Pratt scan, one character comparison per cycle, and reports whether the pattern occurs in the string and where its first occurrence starts. Results go to the engine's output/host-interface stage.

## Interface
Parameters:
- `BYTE`, 8: bits per character
- `MAX_STRING`, 32: string buffer depth in characters
- `MAX_PATTERN`, 8: pattern buffer depth in characters
- `MAX_STR_ADD`, 5: string index width (log2 `MAX_STRING`)
- `MAX_PAT_ADD`, 3: pattern index and failure-entry width (log2 `MAX_PATTERN`)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `i_valid`  in  1  start pulse; buffers and indices are stable while high and while `busy`
- `str_reg`  in  `MAX_STRING*BYTE`  character k at bits [k*BYTE +: BYTE]
- `pat_reg`  in  `MAX_PATTERN*BYTE`  same packing
- `str_last_idx`  in  `MAX_STR_ADD`  index of last valid string character
- `pat_last_idx`  in  `MAX_PAT_ADD`  index of last valid pattern character
- `ff_result`  in  `MAX_PAT_ADD*MAX_PATTERN`  entry k at [k*MAX_PAT_ADD +: MAX_PAT_ADD]; length of the longest proper prefix of pat[0..k] that is also its suffix
- `busy`  out  1  high from the cycle after start until `o_valid`, inclusive
- `match_found`  out  1  pattern found
- `match_idx`  out  `MAX_STR_ADD`  start index of first occurrence; 0 when not found
- `o_valid`  out  1  one-cycle result strobe

## Operation
- States: IDLE, SCAN, DONE. Reset drives state to IDLE and all outputs to 0.
- IDLE: if `i_valid` is high, clear `match_found`/`match_idx` and load s=0, q=0, plen=`pat_last_idx`+1.
  - If `pat_last_idx` > `str_last_idx`, go to DONE with not-found.
  - Otherwise go to SCAN.
- SCAN performs one step per cycle. c = str[s], p = pat[q]:
  - If c==p and q+1==plen: `match_found`=1, `match_idx`=s-q, go to DONE.
  - If c==p otherwise: q++. If s==`str_last_idx`, go to DONE with not-found; else s++.
  - If c!=p and q>0: q = ff[q-1]. s is held.
  - If c!=p and q==0: if s==`str_last_idx`, go to DONE with not-found; else s++.
- DONE: `o_valid`=1 for exactly this cycle, then return to IDLE. `match_found`/`match_idx` hold until the next accepted start.
- q is `MAX_PAT_ADD`+1 bits wide, so it can represent plen = `MAX_PATTERN`. s never wraps; termination is by `str_last_idx` compare.
- Only the first occurrence is reported.
- `i_valid` is ignored in SCAN and DONE; no queuing.
- Asynchronous reset mid-scan aborts the scan. No `o_valid` is produced for the aborted job.

## Timing
- `i_valid` is sampled at edge T0. SCAN steps occur at edges T1..TN. DONE is visible in the cycle after TN, so `o_valid` is high N+1 cycles after the start edge.
- Pattern-longer-than-string case: `o_valid` is high 1 cycle after start.
- Worst case N ≤ 2*(`str_last_idx`+1): each step either advances s or strictly decreases q.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Back-to-back jobs: a new `i_valid` may be accepted in the cycle immediately after `o_valid`.

## Structure
- Shared defines (`BYTE`, `MAX_STRING`, `MAX_PATTERN`, `MAX_STR_ADD`, `MAX_PAT_ADD`) stay in the common SME parameter include. State encodings are localparams here.
- One combinational sub-module, `kmp_step`:
  - Inputs: c, p, q, plen, the ff entry, s==last flag.
  - Outputs: next q, advance-s, hit, end-of-string.
- Byte and ff-entry selection muxes live in the top module.

## Test plan
- String "ABABC", pattern "ABC", ff=[0,0,0], last=4/2 -> 6 SCAN steps, `o_valid` 7 cycles after start, `match_found`=1, `match_idx`=2.
- String "AAAAB", pattern "AAB", ff=[0,1,0] -> `match_found`=1, `match_idx`=2; the fallback step q=ff[1]=1 is exercised.
- String "ABCD", pattern "XY" -> `match_found`=0, `match_idx`=0; `o_valid` after 4 steps (5 cycles).
- Pattern last=5, string last=2 -> `o_valid` 1 cycle after start, not found.
- Match at the final string position (string "XXXAB", pattern "AB") -> `match_idx`=3. Full-size string of 32 characters with its match at index 24 -> `match_idx`=24, no wrap.
- Reset low mid-SCAN, then `i_valid` held high during `busy` -> no `o_valid`, outputs 0 after reset. The extra `i_valid` is ignored and exactly one result is produced per accepted start.

Source files
------------

// File: rtl/kmp_match_engine_pkg.sv
// Shared widths and FSM state type for the KMP match engine.
package kmp_match_engine_pkg;

  localparam int unsigned KMP_BYTE        = 8;
  localparam int unsigned KMP_MAX_STRING  = 32;
  localparam int unsigned KMP_MAX_PATTERN = 8;
  localparam int unsigned KMP_MAX_STR_ADD = 5;
  localparam int unsigned KMP_MAX_PAT_ADD = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } kmp_state_e;

endpackage

// File: rtl/kmp_match_engine_step.sv
// One KMP comparison step: decides the next pattern index, whether the
// string index advances, whether the pattern completed, and whether the
// string ran out without a match.
module kmp_step
  import kmp_match_engine_pkg::*;
#(
  parameter int unsigned BYTE        = KMP_BYTE,
  parameter int unsigned MAX_PAT_ADD = KMP_MAX_PAT_ADD
) (
  input  logic [BYTE-1:0]        i_c,
  input  logic [BYTE-1:0]        i_p,
  input  logic [MAX_PAT_ADD:0]   i_q,
  input  logic [MAX_PAT_ADD:0]   i_plen,
  input  logic [MAX_PAT_ADD-1:0] i_ff,
  input  logic                   i_s_last,
  output logic [MAX_PAT_ADD:0]   o_q_next,
  output logic                   o_adv_s,
  output logic                   o_hit,
  output logic                   o_eos
);

  logic                 w_eq;
  logic [MAX_PAT_ADD:0] w_q_inc;

  assign w_eq    = (i_c == i_p);
  assign w_q_inc = i_q + 1'b1;

  // Step decision; a mismatch with q>0 falls back through the failure table
  // and re-tests the same character, so s is held on that path.
  always_comb begin
    o_q_next = i_q;
    o_adv_s  = 1'b0;
    o_hit    = 1'b0;
    o_eos    = 1'b0;
    if (w_eq) begin
      if (w_q_inc == i_plen) begin
        o_hit = 1'b1;
      end else begin
        o_q_next = w_q_inc;
        o_eos    = i_s_last;
        o_adv_s  = ~i_s_last;
      end
    end else if (i_q != '0) begin
      o_q_next = {1'b0, i_ff};
    end else begin
      o_q_next = '0;
      o_eos    = i_s_last;
      o_adv_s  = ~i_s_last;
    end
  end

endmodule

// File: rtl/kmp_match_engine.sv
// KMP scan engine: one character comparison per cycle over a preloaded
// string/pattern/failure table, reporting the first occurrence.
module kmp_match_engine
  import kmp_match_engine_pkg::*;
#(
  parameter int unsigned BYTE        = KMP_BYTE,
  parameter int unsigned MAX_STRING  = KMP_MAX_STRING,
  parameter int unsigned MAX_PATTERN = KMP_MAX_PATTERN,
  parameter int unsigned MAX_STR_ADD = KMP_MAX_STR_ADD,
  parameter int unsigned MAX_PAT_ADD = KMP_MAX_PAT_ADD
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               i_valid,
  input  logic [MAX_STRING*BYTE-1:0]         str_reg,
  input  logic [MAX_PATTERN*BYTE-1:0]        pat_reg,
  input  logic [MAX_STR_ADD-1:0]             str_last_idx,
  input  logic [MAX_PAT_ADD-1:0]             pat_last_idx,
  input  logic [MAX_PAT_ADD*MAX_PATTERN-1:0] ff_result,
  output logic                               busy,
  output logic                               match_found,
  output logic [MAX_STR_ADD-1:0]             match_idx,
  output logic                               o_valid
);

  localparam int unsigned QW = MAX_PAT_ADD + 1;

  kmp_state_e             r_state, w_state_n;
  logic [MAX_STR_ADD-1:0] r_s, w_s_n;
  logic [QW-1:0]          r_q, w_q_n;
  logic [QW-1:0]          r_plen, w_plen_n;
  logic                   r_found, w_found_n;
  logic [MAX_STR_ADD-1:0] r_idx, w_idx_n;
  logic                   r_busy, r_o_valid;

  logic [BYTE-1:0]        w_c, w_p;
  logic [QW-1:0]          w_qm1;
  logic [MAX_PAT_ADD-1:0] w_ff;
  logic [QW-1:0]          w_q_next;
  logic                   w_adv_s, w_hit, w_eos;

  // Character and failure-entry selection; q stays below plen while scanning.
  assign w_c   = str_reg[int'(r_s) * BYTE +: BYTE];
  assign w_p   = pat_reg[int'(r_q) * BYTE +: BYTE];
  assign w_qm1 = (r_q == '0) ? '0 : r_q - 1'b1;
  assign w_ff  = ff_result[int'(w_qm1) * MAX_PAT_ADD +: MAX_PAT_ADD];

  kmp_step #(
    .BYTE        (BYTE),
    .MAX_PAT_ADD (MAX_PAT_ADD)
  ) u_step (
    .i_c      (w_c),
    .i_p      (w_p),
    .i_q      (r_q),
    .i_plen   (r_plen),
    .i_ff     (w_ff),
    .i_s_last (r_s == str_last_idx),
    .o_q_next (w_q_next),
    .o_adv_s  (w_adv_s),
    .o_hit    (w_hit),
    .o_eos    (w_eos)
  );

  // Next-state and next-datapath decode.
  always_comb begin
    w_state_n = r_state;
    w_s_n     = r_s;
    w_q_n     = r_q;
    w_plen_n  = r_plen;
    w_found_n = r_found;
    w_idx_n   = r_idx;
    unique case (r_state)
      ST_IDLE: begin
        if (i_valid) begin
          w_found_n = 1'b0;
          w_idx_n   = '0;
          w_s_n     = '0;
          w_q_n     = '0;
          w_plen_n  = QW'(pat_last_idx) + QW'(1);
          if (MAX_STR_ADD'(pat_last_idx) > str_last_idx) w_state_n = ST_DONE;
          else                                            w_state_n = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_hit) begin
          w_found_n = 1'b1;
          w_idx_n   = r_s - MAX_STR_ADD'(r_q);
          w_state_n = ST_DONE;
        end else begin
          w_q_n = w_q_next;
          if (w_eos)   w_state_n = ST_DONE;
          if (w_adv_s) w_s_n     = r_s + 1'b1;
        end
      end
      ST_DONE: w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_s       <= '0;
      r_q       <= '0;
      r_plen    <= '0;
      r_found   <= 1'b0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_o_valid <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_s       <= w_s_n;
      r_q       <= w_q_n;
      r_plen    <= w_plen_n;
      r_found   <= w_found_n;
      r_idx     <= w_idx_n;
      r_busy    <= (w_state_n != ST_IDLE);
      r_o_valid <= (w_state_n == ST_DONE);
    end
  end

  assign busy        = r_busy;
  assign match_found = r_found;
  assign match_idx   = r_idx;
  assign o_valid     = r_o_valid;

endmodule
